// File: rtl/mat_pkg.sv
// Shared types and helpers for the mine-matrix load sequencer.
package mat_pkg;

    localparam int AREA_W = 3;
    localparam int DOT_W  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EDIT   = 3'd1,
        COMMIT = 3'd2,
        NEXT   = 3'd3,
        DONE   = 3'd4
    } mat_state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] value);
        logic [4:0] count;
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + 5'(value[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/mat_popcnt16.sv
// Combinational 16-bit population count of the staging pattern.
module mat_popcnt16
    import mat_pkg::*;
(
    input  logic [15:0] value,
    output logic [4:0]  count
);

    assign count = popcount16(value);

endmodule

// File: rtl/mat_load_ctrl.sv
// Load sequencer for the 8x16 mine matrix: walks areas, edits a 4x4 staging
// pattern from keypad codes and commits it with a single-cycle switch pulse.
// Optional per-area mine limit and key_reject output: MAT_LOAD_MINE_LIMIT_EN.
module mat_load_ctrl
    import mat_pkg::*;
#(
    parameter int NUM_AREAS = 8,
    parameter int MAX_MINES = 4
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              confirm,
    input  logic              skip,
    output logic [AREA_W-1:0] area,
    output logic [DOT_W-1:0]  dot,
    output logic              switch,
    output logic              finish,
    output logic              busy,
    output logic [7:0]        area_done,
    output logic [6:0]        mine_total,
    output mat_state_t        state_dbg
`ifdef MAT_LOAD_MINE_LIMIT_EN
    ,
    output logic              key_reject
`endif
);

    localparam logic [AREA_W-1:0] LAST_AREA = AREA_W'(NUM_AREAS - 1);

    if (NUM_AREAS < 1 || NUM_AREAS > 8 || MAX_MINES < 1 || MAX_MINES > 16) begin : g_param_check
        $error("mat_load_ctrl: parameter out of range");
    end

    mat_state_t        state_q, state_d;
    logic [AREA_W-1:0] cur_q;
    logic [DOT_W-1:0]  staging_q;
    logic [DOT_W-1:0]  key_mask;
    logic [4:0]        pop;
    logic              key_fire;
    logic              key_blocked;

    mat_popcnt16 u_popcnt (
        .value (staging_q),
        .count (pop)
    );

    assign key_mask = DOT_W'(1) << (4'd15 - key_code);

`ifdef MAT_LOAD_MINE_LIMIT_EN
    // Only a key that would add a mine can be blocked; clearing is always allowed.
    assign key_blocked = ((staging_q & key_mask) == '0) && (pop == 5'(MAX_MINES));
`else
    assign key_blocked = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        key_fire = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = EDIT;
            EDIT: begin
                // confirm wins over skip, skip wins over a key press
                if (confirm)        state_d = COMMIT;
                else if (skip)      state_d = NEXT;
                else if (key_valid) key_fire = !key_blocked;
            end
            COMMIT:  state_d = NEXT;
            NEXT:    state_d = (cur_q == LAST_AREA) ? DONE : EDIT;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            staging_q  <= '0;
            area_done  <= '0;
            mine_total <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    cur_q     <= '0;
                    staging_q <= '0;
                end
                EDIT: begin
                    if (!confirm && skip) begin
                        area_done[cur_q] <= 1'b1;
                        staging_q        <= '0;
                    end else if (key_fire) begin
                        staging_q <= staging_q ^ key_mask;
                    end
                end
                COMMIT: begin
                    mine_total       <= mine_total + 7'(pop);
                    area_done[cur_q] <= 1'b1;
                    staging_q        <= '0;
                end
                NEXT: if (cur_q != LAST_AREA) cur_q <= cur_q + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MAT_LOAD_MINE_LIMIT_EN
    always_ff @(posedge clock) begin
        if (reset) key_reject <= 1'b0;
        else       key_reject <= (state_q == EDIT) && !confirm && !skip && key_valid && key_blocked;
    end
`endif

    // staging is zero outside EDIT/COMMIT, so dot can mirror it directly
    assign dot       = staging_q;
    assign area      = cur_q;
    assign switch    = (state_q == COMMIT);
    assign finish    = (state_q == DONE);
    assign busy      = (state_q == EDIT) || (state_q == COMMIT) || (state_q == NEXT);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mat_load_ctrl.sv
// Self-checking bench for mat_load_ctrl: directed steps plus randomized
// sessions checked against an area/pattern level reference model.
module tb_mat_load_ctrl;
    import mat_pkg::*;

    localparam int NUM_AREAS = 8;
    localparam int MAX_MINES = 4;

    logic        clock, reset, start, key_valid, confirm, skip;
    logic [3:0]  key_code;
    logic [2:0]  area;
    logic [15:0] dot;
    logic        switch, finish, busy;
    logic [7:0]  area_done;
    logic [6:0]  mine_total;
    mat_state_t  state_dbg;
`ifdef MAT_LOAD_MINE_LIMIT_EN
    logic        key_reject;
`endif

    mat_load_ctrl #(.NUM_AREAS(NUM_AREAS), .MAX_MINES(MAX_MINES)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .confirm    (confirm),
        .skip       (skip),
        .area       (area),
        .dot        (dot),
        .switch     (switch),
        .finish     (finish),
        .busy       (busy),
        .area_done  (area_done),
        .mine_total (mine_total),
        .state_dbg  (state_dbg)
`ifdef MAT_LOAD_MINE_LIMIT_EN
        ,
        .key_reject (key_reject)
`endif
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_switch = 0;

    // scoreboard: expected {area, dot} of every commit, in order
    logic [18:0] exp_q[$];
    logic        prev_switch = 1'b0;

    // reference model
    int          exp_cur;
    logic [15:0] exp_staging;
    logic [7:0]  exp_done;
    int          exp_total;
    bit          exp_fin;
    bit          exp_reject;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (switch === 1'b1) begin
            n_switch++;
            check("switch_single_cycle", 32'(prev_switch), 32'd0);
            if (exp_q.size() == 0) begin
                check("switch_unexpected", 32'd1, 32'd0);
            end else begin
                check("commit_area_dot", 32'({area, dot}), 32'(exp_q.pop_front()));
            end
        end
        prev_switch = switch;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; key_valid = 0; key_code = 0; confirm = 0; skip = 0;
    endtask

    task automatic model_reset();
        exp_cur = 0; exp_staging = '0; exp_done = '0; exp_total = 0;
        exp_fin = 0; exp_reject = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_area"}, 32'(area), 32'd0);
        check({tag, "_dot"}, 32'(dot), 32'd0);
        check({tag, "_switch"}, 32'(switch), 32'd0);
        check({tag, "_finish"}, 32'(finish), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_area_done"}, 32'(area_done), 32'd0);
        check({tag, "_mine_total"}, 32'(mine_total), 32'd0);
`ifdef MAT_LOAD_MINE_LIMIT_EN
        check({tag, "_key_reject"}, 32'(key_reject), 32'd0);
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        model_reset();
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_area", 32'(area), 32'd0);
        check("start_dot", 32'(dot), 32'd0);
    endtask

    task automatic model_key(input int k);
        bit was_set;
        was_set = exp_staging[15-k];
        exp_reject = 0;
`ifdef MAT_LOAD_MINE_LIMIT_EN
        if (!was_set && $countones(exp_staging) == MAX_MINES) exp_reject = 1;
`endif
        if (!exp_reject) exp_staging[15-k] = ~was_set;
    endtask

    task automatic do_key(input int k);
        key_valid = 1;
        key_code = 4'(k);
        tick();
        key_valid = 0;
        model_key(k);
        check("dot_after_key", 32'(dot), 32'(exp_staging));
`ifdef MAT_LOAD_MINE_LIMIT_EN
        check("key_reject", 32'(key_reject), 32'(exp_reject));
`endif
    endtask

    task automatic random_noise();
        start = 1'($urandom_range(0, 1));
        key_valid = 1'($urandom_range(0, 1));
        key_code = 4'($urandom_range(0, 15));
        confirm = 1'($urandom_range(0, 1));
        skip = 1'($urandom_range(0, 1));
    endtask

    task automatic advance_model();
        if (exp_cur == NUM_AREAS - 1) exp_fin = 1;
        else exp_cur++;
    endtask

    task automatic check_after_next(input string tag);
        check({tag, "_finish"}, 32'(finish), 32'(exp_fin));
        check({tag, "_busy"}, 32'(busy), 32'(!exp_fin));
        check({tag, "_area"}, 32'(area), 32'(exp_cur));
        check({tag, "_dot"}, 32'(dot), 32'd0);
    endtask

    // confirm, optionally with a coinciding key press that must be dropped
    task automatic do_confirm(input bit with_key, input int k);
        exp_q.push_back({3'(exp_cur), exp_staging});
        confirm = 1;
        key_valid = with_key;
        key_code = 4'(k);
        tick();
        clear_inputs();
        check("commit_switch", 32'(switch), 32'd1);
        check("commit_dot", 32'(dot), 32'(exp_staging));
        check("commit_area", 32'(area), 32'(exp_cur));
        random_noise();
        tick();
        exp_total += $countones(exp_staging);
        exp_done[exp_cur] = 1;
        exp_staging = '0;
        check("next_switch", 32'(switch), 32'd0);
        check("next_mine_total", 32'(mine_total), 32'(exp_total & 127));
        check("next_area_done", 32'(area_done), 32'(exp_done));
        check("next_dot", 32'(dot), 32'd0);
        random_noise();
        tick();
        clear_inputs();
        advance_model();
        check_after_next("post_commit");
    endtask

    task automatic do_skip();
        skip = 1;
        tick();
        skip = 0;
        exp_done[exp_cur] = 1;
        exp_staging = '0;
        check("skip_switch", 32'(switch), 32'd0);
        check("skip_area_done", 32'(area_done), 32'(exp_done));
        check("skip_finish", 32'(finish), 32'd0);
        tick();
        advance_model();
        check_after_next("post_skip");
    endtask

    task automatic random_session();
        do_reset();
        pulse_start();
        for (int a = 0; a < NUM_AREAS; a++) begin
            int nk;
            nk = $urandom_range(0, 6);
            for (int j = 0; j < nk; j++) do_key($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) do_skip();
            else do_confirm(1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end
        check("session_finish", 32'(finish), 32'd1);
        check("session_mines", 32'(mine_total), 32'(exp_total & 127));
        check("session_area_done", 32'(area_done), 32'hFF);
    endtask

    initial begin
        int sw_before;
        clear_inputs();
        reset = 1;
        model_reset();
        repeat (2) tick();
        reset = 0;
        check_reset_vals("reset");

        // IDLE ignores everything but start
        key_valid = 1; key_code = 0; confirm = 1; skip = 1;
        tick();
        clear_inputs();
        check("idle_ignore_busy", 32'(busy), 32'd0);
        check("idle_ignore_dot", 32'(dot), 32'd0);
        tick();
        check("idle_ignore_switch", 32'(switch), 32'd0);

        // directed pass through one session
        pulse_start();
        do_key(0);
        do_key(5);
        check("dot_8400", 32'(dot), 32'h8400);
        do_confirm(0, 0);
        check("first_mines", 32'(mine_total), 32'd2);
        check("first_done", 32'(area_done), 32'h01);
        do_key(3);
        do_key(3);
        do_confirm(0, 0);
        check("zero_commit_mines", 32'(mine_total), 32'd2);
        do_key(7);
        do_confirm(1, 0);
        check("dropped_key_staging", 32'(dot), 32'd0);
        for (int a = 3; a < NUM_AREAS; a++) begin
            do_key($urandom_range(0, 15));
            do_confirm(0, 0);
        end
        check("directed_finish", 32'(finish), 32'd1);

        // skip every area
        do_reset();
        check_reset_vals("reset_from_done");
        sw_before = n_switch;
        pulse_start();
        for (int a = 0; a < NUM_AREAS; a++) do_skip();
        check("skip_all_no_switch", 32'(n_switch - sw_before), 32'd0);
        check("skip_all_done", 32'(area_done), 32'hFF);
        check("skip_all_mines", 32'(mine_total), 32'd0);

        // DONE ignores all strobes
        start = 1; key_valid = 1; key_code = 2; confirm = 1; skip = 1;
        repeat (2) tick();
        clear_inputs();
        check("done_hold_finish", 32'(finish), 32'd1);
        check("done_hold_busy", 32'(busy), 32'd0);
        check("done_hold_dot", 32'(dot), 32'd0);
        check("done_hold_area", 32'(area), 32'(NUM_AREAS - 1));
        check("done_hold_switch", 32'(switch), 32'd0);

        // reset during COMMIT of area 4
        do_reset();
        pulse_start();
        for (int a = 0; a < 4; a++) do_skip();
        do_key(1);
        do_key(9);
        exp_q.push_back({3'(exp_cur), exp_staging});
        confirm = 1;
        tick();
        confirm = 0;
        check("mid_commit_switch", 32'(switch), 32'd1);
        check("mid_commit_area", 32'(area), 32'd4);
        reset = 1;
        tick();
        reset = 0;
        model_reset();
        check_reset_vals("mid_commit_reset");
        tick();
        pulse_start();

`ifdef MAT_LOAD_MINE_LIMIT_EN
        do_reset();
        pulse_start();
        for (int k = 0; k < 5; k++) do_key(k);
        check("limit_staging", 32'(dot), 32'hF000);
        do_key(0);
        check("limit_clear", 32'(dot), 32'h7000);
`endif

        for (int s = 0; s < 3; s++) random_session();

        repeat (2) tick();
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
